// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, counter type and shared helpers for vga_controller.
package vga_pkg;
    localparam int CNT_W     = 10;
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic logic in_window(cnt_t v, int lo, int hi);
        return (v >= cnt_t'(lo)) && (v < cnt_t'(hi));
    endfunction
endpackage

// File: rtl/vga_if.sv
// vga_if: pixel-generator and DAC signals of the VGA controller; master = controller side.
interface vga_if;
    import vga_pkg::*;
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    cnt_t       x;
    cnt_t       y;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       vga_blank_n;
    logic       vga_sync_n;
    logic       vga_clk;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       frame_start;

    modport master (
        input  r_in, g_in, b_in,
        output x, y, vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, vga_clk,
        output vga_r, vga_g, vga_b, frame_start
    );

    modport slave (
        output r_in, g_in, b_in,
        input  x, y, vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, vga_clk,
        input  vga_r, vga_g, vga_b, frame_start
    );
endinterface

// File: rtl/vga_counter.sv
// vga_counter: tick-enabled counter running 0..MAX; o_wrap flags the terminal count.
module vga_counter
    import vga_pkg::*;
#(
    parameter int MAX = H_TOTAL - 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output cnt_t o_cnt,
    output logic o_wrap
);
    localparam cnt_t L_MAX = cnt_t'(MAX);

    cnt_t r_cnt;

    assign o_wrap = (r_cnt == L_MAX);
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (i_en) r_cnt <= o_wrap ? '0 : r_cnt + cnt_t'(1);
    end
endmodule

// File: rtl/vga_controller.sv
// vga_controller: 640x480@60 timing generator with DAC outputs registered one pixel tick behind x,y.
// Define VGA_CLK_DIV2_EN to run from a 50 MHz clk with an internal divide-by-2 pixel tick.
module vga_controller
    import vga_pkg::*;
#(
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   H_VIS       = H_VISIBLE,
    parameter int   H_FP        = H_FRONT,
    parameter int   H_SY        = H_SYNC,
    parameter int   H_BP        = H_BACK,
    parameter int   V_VIS       = V_VISIBLE,
    parameter int   V_FP        = V_FRONT,
    parameter int   V_SY        = V_SYNC,
    parameter int   V_BP        = V_BACK
) (
    input logic    clk,
    input logic    rst_n,
    vga_if.master  bus
);
    localparam int   L_HT = H_VIS + H_FP + H_SY + H_BP;
    localparam int   L_VT = V_VIS + V_FP + V_SY + V_BP;
    localparam cnt_t L_HV = cnt_t'(H_VIS);
    localparam cnt_t L_VV = cnt_t'(V_VIS);

    logic w_pix_en;
    logic w_h_wrap;
    logic w_v_wrap;
    logic w_h_vis;
    logic w_v_vis;
    logic w_active;
    logic w_hs_on;
    logic w_vs_on;
    cnt_t w_h_cnt;
    cnt_t w_v_cnt;
    rgb_t r_rgb;
    logic r_hs;
    logic r_vs;
    logic r_blank_n;
    logic r_frame_start;

`ifdef VGA_CLK_DIV2_EN
    logic r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_div <= 1'b0;
        else r_div <= ~r_div;
    end

    // DAC clock rises mid-pixel, after the registered colour has settled
    assign w_pix_en    = r_div;
    assign bus.vga_clk = r_div;
`else
    assign w_pix_en    = 1'b1;
    assign bus.vga_clk = clk;
`endif

    vga_counter #(.MAX(L_HT - 1)) u_h_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_pix_en),
        .o_cnt  (w_h_cnt),
        .o_wrap (w_h_wrap)
    );

    vga_counter #(.MAX(L_VT - 1)) u_v_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_pix_en && w_h_wrap),
        .o_cnt  (w_v_cnt),
        .o_wrap (w_v_wrap)
    );

    always_comb begin
        w_h_vis  = w_h_cnt < L_HV;
        w_v_vis  = w_v_cnt < L_VV;
        w_active = w_h_vis && w_v_vis;
        w_hs_on  = in_window(w_h_cnt, H_VIS + H_FP, H_VIS + H_FP + H_SY);
        w_vs_on  = in_window(w_v_cnt, V_VIS + V_FP, V_VIS + V_FP + V_SY);
        bus.x    = w_h_vis ? w_h_cnt : '0;
        bus.y    = w_v_vis ? w_v_cnt : '0;
    end

    // Sync and blank share the colour's one-tick delay so the DAC sees them aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb         <= '0;
            r_hs          <= ~SYNC_ACTIVE;
            r_vs          <= ~SYNC_ACTIVE;
            r_blank_n     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_pix_en && w_h_wrap && w_v_wrap;
            if (w_pix_en) begin
                r_rgb     <= w_active ? rgb_t'({bus.r_in, bus.g_in, bus.b_in}) : '0;
                r_hs      <= w_hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                r_vs      <= w_vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                r_blank_n <= w_active;
            end
        end
    end

    assign bus.vga_r       = r_rgb.r;
    assign bus.vga_g       = r_rgb.g;
    assign bus.vga_b       = r_rgb.b;
    assign bus.vga_hsync   = r_hs;
    assign bus.vga_vsync   = r_vs;
    assign bus.vga_blank_n = r_blank_n;
    assign bus.vga_sync_n  = 1'b0;
    assign bus.frame_start = r_frame_start;
endmodule
